// File: rtl/pipe_exec_ctrl.sv
// rtl/pipe_exec_ctrl.sv - global pipeline enable controller: run/step/pause/clear commands, halt drain, enabled-cycle counter
module pipe_exec_ctrl #(
    parameter int NBITS        = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cmd_valid,
    input  logic [1:0]       i_cmd,
    output logic             o_cmd_ready,
    input  logic             i_halt,
    output logic             o_pipe_en,
    output logic             o_step_done,
    output logic             o_done,
    output logic [2:0]       o_state,
    output logic [NBITS-1:0] o_cycle_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        STEP  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [1:0] CMD_PAUSE = 2'b00;
    localparam logic [1:0] CMD_RUN   = 2'b01;
    localparam logic [1:0] CMD_STEP  = 2'b10;
    localparam logic [1:0] CMD_CLEAR = 2'b11;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    state_t     state, state_next;
    logic [3:0] drain_cnt, drain_next;
    logic       step_done_next;
    logic       clear;
    logic       accept;

    // Every output below is a decode of registered state, so reset drops
    // the enable without waiting for a clock edge.
    assign o_pipe_en   = (state == RUN) || (state == STEP) || (state == DRAIN);
    assign o_cmd_ready = (state == IDLE) || (state == RUN) || (state == DONE);
    assign o_done      = (state == DONE);
    assign o_state     = state;
    assign accept      = i_cmd_valid & o_cmd_ready;

    always_comb begin
        state_next     = state;
        drain_next     = drain_cnt;
        step_done_next = 1'b0;
        clear          = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (i_cmd)
                        CMD_RUN:   state_next = RUN;
                        CMD_STEP:  state_next = STEP;
                        CMD_CLEAR: clear      = 1'b1;
                        default:   state_next = IDLE;
                    endcase
                end
            end
            RUN: begin
                if (i_halt) begin
                    state_next = DRAIN;
                    drain_next = DRAIN_LOAD;
                end else if (accept && (i_cmd == CMD_PAUSE)) begin
                    state_next = IDLE;
                end
            end
            STEP: begin
                if (i_halt) begin
                    state_next = DRAIN;
                    drain_next = DRAIN_LOAD;
                end else begin
                    state_next     = IDLE;
                    step_done_next = 1'b1;
                end
            end
            DRAIN: begin
                drain_next = drain_cnt - 4'd1;
                if (drain_cnt == 4'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (accept && (i_cmd == CMD_CLEAR)) begin
                    state_next = IDLE;
                    clear      = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                drain_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            drain_cnt   <= 4'd0;
            o_step_done <= 1'b0;
        end else begin
            state       <= state_next;
            drain_cnt   <= drain_next;
            o_step_done <= step_done_next;
        end
    end

    // Saturating counter; clear only happens while the pipeline is disabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cycle_count <= '0;
        end else if (clear) begin
            o_cycle_count <= '0;
        end else if (o_pipe_en && (o_cycle_count != {NBITS{1'b1}})) begin
            o_cycle_count <= o_cycle_count + NBITS'(1);
        end
    end

endmodule

// File: tb/tb_pipe_exec_ctrl.sv
// tb/tb_pipe_exec_ctrl.sv - scoreboard bench for pipe_exec_ctrl with a behavioural reference model
module tb_pipe_exec_ctrl;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd = 2'b00;
    logic        halt = 1'b0;

    logic        rdy, pen, sdone, done;
    logic [2:0]  st;
    logic [31:0] cnt;
    logic        rdy4, pen4, sdone4, done4;
    logic [2:0]  st4;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    pipe_exec_ctrl #(.NBITS(32), .DRAIN_CYCLES(D)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .o_cmd_ready(rdy), .i_halt(halt), .o_pipe_en(pen), .o_step_done(sdone),
        .o_done(done), .o_state(st), .o_cycle_count(cnt)
    );

    pipe_exec_ctrl #(.NBITS(4), .DRAIN_CYCLES(D)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .i_cmd(cmd),
        .o_cmd_ready(rdy4), .i_halt(halt), .o_pipe_en(pen4), .o_step_done(sdone4),
        .o_done(done4), .o_state(st4), .o_cycle_count(cnt4)
    );

    typedef struct {
        int          mode;
        bit          en;
        bit          ready;
        bit          dn;
        bit          sd;
        longint      count;
        longint      count4;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    // Reference model: mode numbers follow the reported state codes.
    int     m_mode = 0;
    int     m_left = 0;
    bit     m_sd = 0;
    longint m_cnt = 0;
    longint m_cnt4 = 0;

    function automatic bit m_en();
        return (m_mode == 1) || (m_mode == 2) || (m_mode == 3);
    endfunction

    function automatic bit m_ready();
        return (m_mode == 0) || (m_mode == 1) || (m_mode == 4);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_sd = 0; m_cnt = 0; m_cnt4 = 0;
    endtask

    task automatic model_step(input bit v, input logic [1:0] c, input bit h);
        bit en;
        bit acc;
        bit clr;
        int nm;
        en  = m_en();
        acc = v && m_ready();
        clr = 0;
        nm  = m_mode;
        m_sd = 0;
        if (m_mode == 0) begin
            if (acc && c == 2'd1) nm = 1;
            if (acc && c == 2'd2) nm = 2;
            if (acc && c == 2'd3) clr = 1;
        end else if (m_mode == 1) begin
            if (h) begin nm = 3; m_left = D; end
            else if (acc && c == 2'd0) nm = 0;
        end else if (m_mode == 2) begin
            if (h) begin nm = 3; m_left = D; end
            else begin nm = 0; m_sd = 1; end
        end else if (m_mode == 3) begin
            m_left = m_left - 1;
            if (m_left == 0) nm = 4;
        end else begin
            if (acc && c == 2'd3) begin nm = 0; clr = 1; end
        end
        if (clr) begin
            m_cnt = 0; m_cnt4 = 0;
        end else if (en) begin
            if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
        end
        m_mode = nm;
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.mode = m_mode; e.en = m_en(); e.ready = m_ready(); e.dn = (m_mode == 4);
        e.sd = m_sd; e.count = m_cnt; e.count4 = m_cnt4;
        return e;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input bit v, input logic [1:0] c, input bit h);
        @(negedge clk);
        cmd_valid = v; cmd = c; halt = h;
        q.push_back(snapshot());
        model_step(v, c, h);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 2'd0, 0);
    endtask

    // Monitor: compares the DUT against the next expected snapshot every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("state", st, e.mode);
                chk("pipe_en", pen, e.en);
                chk("cmd_ready", rdy, e.ready);
                chk("done", done, e.dn);
                chk("step_done", sdone, e.sd);
                chk("cycle_count", cnt, e.count);
                chk("cycle_count4", cnt4, e.count4);
                chk("pipe_en4", pen4, e.en);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int steps;
        // reset
        tick(0, 2'd0, 0);
        rst_n = 1'b1;
        idle(2);

        // 1: RUN for 10 enabled cycles, then PAUSE
        tick(1, 2'd1, 0);
        idle(9);
        tick(1, 2'd0, 0);
        idle(1);
        #2;
        chk("t1_count", cnt, 10);
        chk("t1_state", st, 0);
        tick(1, 2'd3, 0);
        idle(1);

        // 2: three STEPs spaced 3 cycles apart
        steps = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1, 2'd2, 0);
            tick(0, 2'd0, 0);
            #2;
            steps += int'(pen);
            tick(0, 2'd0, 0);
            #2;
            steps += int'(sdone);
        end
        idle(1);
        #2;
        chk("t2_count", cnt, 3);
        chk("t2_pulses", steps, 6);
        tick(1, 2'd3, 0);

        // 3: halt at enabled cycle 7, drain, DONE, ignored commands, CLEAR
        tick(1, 2'd1, 0);
        idle(6);
        tick(0, 2'd0, 1);
        idle(D + 1);
        #2;
        chk("t3_done", done, 1);
        chk("t3_count", cnt, 11);
        tick(1, 2'd1, 0);
        tick(1, 2'd2, 0);
        idle(1);
        #2;
        chk("t3_ignored", st, 4);
        tick(1, 2'd3, 0);
        idle(1);
        #2;
        chk("t3_clear", cnt, 0);

        // 4: STEP with halt in the step cycle
        tick(1, 2'd2, 0);
        tick(0, 2'd0, 1);
        idle(D + 1);
        #2;
        chk("t4_count", cnt, 5);
        chk("t4_done", done, 1);
        tick(1, 2'd3, 0);

        // 5: halt and PAUSE together in RUN; halt wins
        tick(1, 2'd1, 0);
        idle(2);
        tick(1, 2'd0, 1);
        tick(1, 2'd0, 0);
        #2;
        chk("t5_drain", st, 3);
        chk("t5_ready", rdy, 0);
        idle(D + 1);
        tick(1, 2'd3, 0);

        // 6: saturation of the narrow counter, then async reset mid-DRAIN
        tick(1, 2'd1, 0);
        idle(20);
        #2;
        chk("t6_sat", cnt4, 15);
        tick(0, 2'd0, 1);
        idle(2);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_async_en", pen, 0);
        chk("t6_async_state", st, 0);
        tick(0, 2'd0, 0);
        rst_n = 1'b1;
        idle(1);

        // randomized phase
        for (int i = 0; i < 1500; i++) begin
            tick($urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);
        end
        idle(3);
        #3;
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
